// File: rtl/sbox_arbiter.sv
// sbox_arbiter: round-robin/lockable arbiter sharing one pipelined S-box read port among NUM_REQ requesters
module sbox_arbiter #(
  parameter int NUM_REQ  = 2,
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_lock,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 sbox_rd_en,
  output logic [7:0]           sbox_rqst_addr,
  input  logic [7:0]           sbox_read_data,
  output logic                 busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int D  = SBOX_LAT + 1;
  logic [IW-1:0] ptr, win, lock_own;
  logic          lock_on, acc;
  logic [D-1:0]  tag_v;
  logic [IW-1:0] tag_id [D];
  // first valid requester at or above ptr (wrapping); a held lock restricts the grant to its owner
  always_comb begin
    win = ptr;
    acc = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (req_valid[j]) begin
        win = IW'(j);
        acc = 1'b1;
      end
    end
    if (lock_on) begin
      win = lock_own;
      acc = req_valid[lock_own];
    end
    acc = acc & rst;
  end
  assign req_ready = acc ? NUM_REQ'(1) << win : '0;
  assign busy = (|tag_v) | (|rsp_valid) | lock_on;
  // round-robin pointer and lock owner advance only on an accepted transfer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr      <= '0;
      lock_on  <= 1'b0;
      lock_own <= '0;
    end else if (acc) begin
      ptr      <= (win == IW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
      lock_on  <= req_lock[win];
      lock_own <= win;
    end
  end
  // S-box request, requester tag pipeline and response capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sbox_rd_en     <= 1'b0;
      sbox_rqst_addr <= '0;
      tag_v          <= '0;
      for (int i = 0; i < D; i++) tag_id[i] <= '0;
      rsp_valid      <= '0;
      rsp_data       <= '0;
    end else begin
      sbox_rd_en <= acc;
      if (acc) sbox_rqst_addr <= req_addr[{win, 3'b000} +: 8];
      tag_v     <= {tag_v[D-2:0], acc};
      tag_id[0] <= win;
      for (int i = 1; i < D; i++) tag_id[i] <= tag_id[i-1];
      rsp_valid <= tag_v[D-1] ? NUM_REQ'(1) << tag_id[D-1] : '0;
      if (tag_v[D-1]) rsp_data <= sbox_read_data;
    end
  end
endmodule

// File: tb/tb_sbox_arbiter.sv
// tb_sbox_arbiter: directed and random checks of two sbox_arbiter instances (SBOX_LAT 1 and 3) against a cycle-scheduled reference
module tb_sbox_arbiter;
  localparam int N = 2048;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst;
  logic [1:0] req_valid, req_lock;
  logic [15:0] req_addr;
  logic [1:0] rdy1, rv1, rdy3, rv3;
  logic [7:0] rdat1, ra1, sd1, rdat3, ra3, sd3;
  logic       rd1, rd3, busy1, busy3;
  logic [7:0] p3 [3];
  logic [127:0] rows [16] = '{
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  sbox_arbiter #(.NUM_REQ(2), .SBOX_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_lock(req_lock),
    .req_ready(rdy1), .rsp_valid(rv1), .rsp_data(rdat1), .sbox_rd_en(rd1),
    .sbox_rqst_addr(ra1), .sbox_read_data(sd1), .busy(busy1));
  sbox_arbiter #(.NUM_REQ(2), .SBOX_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_lock(req_lock),
    .req_ready(rdy3), .rsp_valid(rv3), .rsp_data(rdat3), .sbox_rd_en(rd3),
    .sbox_rqst_addr(ra3), .sbox_read_data(sd3), .busy(busy3));
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    logic [127:0] r;
    int s;
    r = rows[a[7:4]];
    s = 8 * (15 - int'(a[3:0]));
    return r[s +: 8];
  endfunction
  // S-box memories of latency 1 and 3; junk data when not read so stray captures show up
  always @(posedge clk) begin
    sd1   <= rd1 ? sbox_f(ra1) : 8'($urandom);
    p3[0] <= rd3 ? sbox_f(ra3) : 8'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign sd3 = p3[2];
  int tests = 0, fails = 0, cyc = 0;
  int ptr, lock_on, lock_own, last_acc;
  int rsp_id1 [N], rsp_id3 [N];
  logic [7:0] rsp_d1 [N], rsp_d3 [N], addr_s [N];
  bit rd_s [N];
  logic [7:0] hold1, hold3, hold_addr;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask
  task automatic model_reset();
    ptr = 0; lock_on = 0; lock_own = 0; last_acc = -100;
    hold1 = 8'h00; hold3 = 8'h00; hold_addr = 8'h00;
    for (int i = cyc; i < N; i++) begin
      rsp_id1[i] = -1; rsp_id3[i] = -1; rd_s[i] = 1'b0;
    end
  endtask
  task automatic check_cycle(input logic [1:0] er);
    if (rd_s[cyc]) hold_addr = addr_s[cyc];
    if (rsp_id1[cyc] >= 0) hold1 = rsp_d1[cyc];
    if (rsp_id3[cyc] >= 0) hold3 = rsp_d3[cyc];
    chk("ready1", 32'(rdy1), 32'(er));
    chk("ready3", 32'(rdy3), 32'(er));
    chk("rd_en1", 32'(rd1), 32'(rd_s[cyc]));
    chk("rd_en3", 32'(rd3), 32'(rd_s[cyc]));
    chk("addr1", 32'(ra1), 32'(hold_addr));
    chk("addr3", 32'(ra3), 32'(hold_addr));
    chk("rsp_valid1", 32'(rv1), rsp_id1[cyc] < 0 ? 32'd0 : 32'd1 << rsp_id1[cyc]);
    chk("rsp_valid3", 32'(rv3), rsp_id3[cyc] < 0 ? 32'd0 : 32'd1 << rsp_id3[cyc]);
    chk("rsp_data1", 32'(rdat1), 32'(hold1));
    chk("rsp_data3", 32'(rdat3), 32'(hold3));
    chk("busy1", 32'(busy1), 32'(lock_on != 0 || (cyc > last_acc && cyc <= last_acc + 3)));
    chk("busy3", 32'(busy3), 32'(lock_on != 0 || (cyc > last_acc && cyc <= last_acc + 5)));
  endtask
  task automatic step(input logic [1:0] v, input logic [7:0] a0, input logic [7:0] a1, input logic [1:0] lk);
    int w;
    logic [7:0] wa;
    @(negedge clk);
    rst = 1'b1; req_valid = v; req_addr = {a1, a0}; req_lock = lk;
    #1;
    w = -1;
    if (lock_on != 0) w = v[lock_own] ? lock_own : -1;
    else for (int k = 0; k < 2; k++) if (w < 0 && v[(ptr + k) % 2]) w = (ptr + k) % 2;
    check_cycle(w < 0 ? 2'b00 : 2'(1 << w));
    if (w >= 0) begin
      wa = (w == 1) ? a1 : a0;
      rd_s[cyc+1] = 1'b1; addr_s[cyc+1] = wa;
      rsp_id1[cyc+3] = w; rsp_d1[cyc+3] = sbox_f(wa);
      rsp_id3[cyc+5] = w; rsp_d3[cyc+5] = sbox_f(wa);
      last_acc = cyc;
      ptr = (w + 1) % 2;
      lock_on = int'(lk[w]);
      lock_own = w;
    end
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    model_reset();
    check_cycle(2'b00);
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 8'h00, 8'h00, 2'b00);
  endtask
  initial begin
    rst = 1'b0; req_valid = 2'b00; req_addr = 16'h0000; req_lock = 2'b00;
    do_reset();
    for (int i = 0; i < 4; i++) step(2'b11, 8'(8'h10 + i), 8'(8'h20 + i), 2'b00);
    idle(6);
    step(2'b01, 8'h53, 8'h00, 2'b00);
    idle(6);
    for (int i = 0; i < 15; i++) step(2'b11, 8'(8'h40 + i), 8'(8'h80 + i), 2'b10);
    step(2'b11, 8'h4f, 8'h8f, 2'b00);
    for (int i = 0; i < 3; i++) step(2'b11, 8'(8'h60 + i), 8'(8'h90 + i), 2'b00);
    idle(6);
    step(2'b10, 8'h00, 8'hA5, 2'b10);
    for (int i = 0; i < 3; i++) step(2'b01, 8'(8'h30 + i), 8'h00, 2'b00);
    step(2'b10, 8'h00, 8'h5A, 2'b00);
    idle(6);
    for (int i = 0; i < 8; i++) step(2'b01, 8'(i), 8'h00, 2'b00);
    idle(8);
    step(2'b01, 8'h11, 8'h00, 2'b00);
    step(2'b10, 8'h00, 8'h22, 2'b00);
    do_reset();
    step(2'b01, 8'h53, 8'h00, 2'b00);
    idle(7);
    for (int i = 0; i < 400; i++)
      step(2'($urandom), 8'($urandom), 8'($urandom), ($urandom % 4 == 0) ? 2'($urandom) : 2'b00);
    idle(8);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sbox_arbiter.md
SBOX_ARBITER -- requirements
Module: sbox_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing the S-box (legal range 2..4).
REQ-002 Parameter SBOX_LAT, default 1, S-box read latency in cycles from sampled sbox_rd_en to valid sbox_read_data (legal range 1..4).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester lookup request.
REQ-006 req_addr  input  8*NUM_REQ  per-requester S-box index; requester i uses bits [8i+7:8i].
REQ-007 req_lock  input  NUM_REQ  per-requester lock hint, sampled with the accepted request.
REQ-008 req_ready  output  NUM_REQ  one-hot grant; the request is accepted in any cycle where req_valid[i] and req_ready[i] are both 1.
REQ-009 rsp_valid  output  NUM_REQ  one-hot response strobe; one cycle wide, no backpressure.
REQ-010 rsp_data  output  8  substituted byte; shared by all requesters and qualified by rsp_valid.
REQ-011 sbox_rd_en  output  1  S-box read strobe, registered.
REQ-012 sbox_rqst_addr  output  8  S-box address, registered.
REQ-013 sbox_read_data  input  8  S-box read data.
REQ-014 busy  output  1  high while any lookup is in flight or a lock is held.

Function
REQ-015 At most one bit of req_ready shall be high per cycle.
REQ-016 req_ready shall be combinational from req_valid, the round-robin pointer and the lock state, with no dependence on req_ready itself.
REQ-017 When unlocked, the grant shall go to the first requester with req_valid=1, searching upward from the round-robin pointer with wrap from NUM_REQ-1 to 0.
REQ-018 After each accepted transfer, the pointer shall move to (winner+1) mod NUM_REQ; it shall not move when nothing is accepted.
REQ-019 An accepted transfer with req_lock=1 shall set the lock to the winner; an accepted transfer by the owner with req_lock=0 shall clear it.
REQ-020 While locked, only the owner shall be granted; if the owner's req_valid is low, no grant is issued that cycle.
REQ-021 A transfer accepted in cycle T shall drive sbox_rd_en=1 and sbox_rqst_addr=the winner's address in cycle T+1.
REQ-022 In cycle T+1+SBOX_LAT the block shall capture sbox_read_data.
REQ-023 In cycle T+2+SBOX_LAT the block shall drive rsp_valid[winner]=1 with rsp_data equal to the captured byte; the total latency is SBOX_LAT+2 cycles.
REQ-024 The datapath shall be fully pipelined: one acceptance per cycle is sustainable, and requester IDs travel in a tag shift register of depth SBOX_LAT+1.
REQ-025 Responses shall return in acceptance order; back-to-back responses to different requesters in consecutive cycles are legal.
REQ-026 When no transfer is accepted, sbox_rd_en shall be 0 the next cycle and sbox_rqst_addr shall hold its last value.
REQ-027 rsp_data shall hold its last value when rsp_valid is all-zero.
REQ-028 busy shall be high while any tag stage is valid, rsp_valid is nonzero, or the lock is set.

Reset
REQ-029 While rst=0, the block shall hold: req_ready=0, rsp_valid=0, rsp_data=0, sbox_rd_en=0, sbox_rqst_addr=0, busy=0, pointer=0, lock cleared, all tag stages invalid.
REQ-030 Asserting rst mid-operation shall discard all in-flight lookups; no rsp_valid shall be issued for them after reset release.
REQ-031 After rst deasserts, requests shall be accepted from the first clock edge.

Verification
REQ-032 Single request: NUM_REQ=2, SBOX_LAT=1, req_valid=01, addr0=0x53, S-box model returns 0xED -> sbox_rd_en at T+1 with addr 0x53, rsp_valid=01 with rsp_data=0xED at T+3, busy low from T+4.
REQ-033 Contention: both requesters hold req_valid=11 for 4 cycles with pointer=0 -> grants alternate 0,1,0,1, and responses alternate with matching data each cycle.
REQ-034 Lock burst: requester 1 issues 16 transfers with req_lock=1, the last with req_lock=0, while requester 0 requests continuously -> requester 0 gets no grant for 16 cycles, then is granted in the next cycle.
REQ-035 Locked idle: owner drops req_valid for 3 cycles while locked and the other requester is valid -> req_ready=00 for those cycles and busy stays 1.
REQ-036 Pipeline fill: SBOX_LAT=3, 8 back-to-back accepts with addresses 0x00..0x07 -> 8 consecutive rsp_valid cycles starting at T+5, data 0x63,0x7C,0x77,0x7B,0xF2,0x6B,0x6F,0xC5.
REQ-037 Reset mid-flight: rst=0 for one cycle while 2 lookups are in flight -> all outputs reset immediately, no rsp_valid after release, and a new request succeeds on the first edge.
